// File: rtl/gate_pattern_decoder.sv
// Receive-side DAB gate-pattern decoder: recovers period, V1/V2 pulse widths, phase offset and
// minimum leg-A deadtime per switching period. Shoot-through flag enabled by GATE_PATTERN_SHOOT_THROUGH_EN.
module gate_pattern_decoder #(
    parameter int CNT_W = 16,
    parameter int DT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic [3:0]       Sp,
    input  logic [3:0]       Ss,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] v1_pos_cnt,
    output logic [CNT_W-1:0] v2_pos_cnt,
    output logic [CNT_W:0]   phase_cnt,
    output logic             phase_ok,
    output logic [DT_W-1:0]  dt_cnt,
    output logic             meas_valid,
    output logic             timeout,
    output logic             fault
);
    localparam logic [0:0]       IDLE    = 1'b0;
    localparam logic [0:0]       MEAS    = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [DT_W-1:0]  DT_MAX  = '1;
    localparam logic [DT_W-1:0]  DT_ONE  = DT_W'(1);

    logic             v1_pos, v2_pos, leg_a_dead;
    logic             trig_d, v1_d, v2_d;
    logic [1:0]       leg_a_d;
    logic             trig_rise, v1_rise, v2_rise, leg_a_rise;
    logic [0:0]       state;
    logic [CNT_W-1:0] tcnt, v1_cnt, v2_cnt, t_v1, t_v2;
    logic [CNT_W-1:0] v1_inc, v2_inc;
    logic             v1_seen, v2_seen;
    logic [DT_W-1:0]  dt_run, dt_min, dt_min_upd;

    // Only the +1 level of each bridge is measured, so the -1 decode is not needed here.
    assign v1_pos     = Sp[3] & Sp[0];
    assign v2_pos     = Ss[3] & Ss[0];
    assign leg_a_dead = ~(Sp[3] | Sp[2]);

    assign trig_rise  = trigger & ~trig_d;
    assign v1_rise    = v1_pos & ~v1_d;
    assign v2_rise    = v2_pos & ~v2_d;
    assign leg_a_rise = |(Sp[3:2] & ~leg_a_d);

    assign v1_inc     = {{(CNT_W-1){1'b0}}, v1_pos};
    assign v2_inc     = {{(CNT_W-1){1'b0}}, v2_pos};
    assign dt_min_upd = (dt_run < dt_min) ? dt_run : dt_min;

    // Edge history and the saturating leg-A dead run; both free-run independent of the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_d  <= 1'b0;
            v1_d    <= 1'b0;
            v2_d    <= 1'b0;
            leg_a_d <= 2'b00;
            dt_run  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            trig_d  <= trigger;
            v1_d    <= v1_pos;
            v2_d    <= v2_pos;
            leg_a_d <= Sp[3:2];
            if (!leg_a_dead)
                dt_run <= '0;
            else if (dt_run != DT_MAX)
                dt_run <= dt_run + DT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tcnt       <= '0;
            v1_cnt     <= '0;
            v2_cnt     <= '0;
            t_v1       <= '0;
            t_v2       <= '0;
            v1_seen    <= 1'b0;
            v2_seen    <= 1'b0;
            dt_min     <= '0;
            period_cnt <= '0;
            v1_pos_cnt <= '0;
            v2_pos_cnt <= '0;
            phase_cnt  <= '0;
            phase_ok   <= 1'b0;
            dt_cnt     <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (trig_rise) begin
                if (state == MEAS) begin
                    // Close the running period; the trigger-cycle sample still belongs to it.
                    period_cnt <= tcnt + CNT_ONE;
                    v1_pos_cnt <= v1_cnt + v1_inc;
                    v2_pos_cnt <= v2_cnt + v2_inc;
                    phase_ok   <= v1_seen & v2_seen;
                    phase_cnt  <= (v1_seen & v2_seen) ? ({1'b0, t_v2} - {1'b0, t_v1}) : '0;
                    dt_cnt     <= dt_min;
                    meas_valid <= 1'b1;
                end
                // Restart; edges coinciding with the trigger open the new period at t=0.
                state   <= MEAS;
                tcnt    <= '0;
                v1_cnt  <= '0;
                v2_cnt  <= '0;
                t_v1    <= '0;
                t_v2    <= '0;
                v1_seen <= v1_rise;
                v2_seen <= v2_rise;
                dt_min  <= leg_a_rise ? dt_run : DT_MAX;
            end else if (state == MEAS) begin
                if (tcnt == CNT_MAX) begin
                    timeout <= 1'b1;
                    state   <= IDLE;
                end else begin
                    tcnt   <= tcnt + CNT_ONE;
                    v1_cnt <= v1_cnt + v1_inc;
                    v2_cnt <= v2_cnt + v2_inc;
                    if (v1_rise && !v1_seen) begin
                        t_v1    <= tcnt;
                        v1_seen <= 1'b1;
                    end
                    if (v2_rise && !v2_seen) begin
                        t_v2    <= tcnt;
                        v2_seen <= 1'b1;
                    end
                    if (leg_a_rise)
                        dt_min <= dt_min_upd;
                end
            end
        end
    end

`ifdef GATE_PATTERN_SHOOT_THROUGH_EN
    logic shoot;
    assign shoot = (Sp[3] & Sp[2]) | (Sp[1] & Sp[0]) | (Ss[3] & Ss[2]) | (Ss[1] & Ss[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fault <= 1'b0;
        else if (shoot)
            fault <= 1'b1;
    end
`else
    // Leg-B primary and leg-A/B secondary complements only matter for shoot-through detection.
    logic unused_gates;
    assign unused_gates = &{1'b0, Sp[1], Ss[2:1]};
    assign fault        = 1'b0;
`endif

endmodule

// File: tb/tb_gate_pattern_decoder.sv
// Scoreboard bench for gate_pattern_decoder: directed gate patterns per 1000-cycle period,
// expected captures queued at each closing trigger and checked by an independent monitor.
module tb_gate_pattern_decoder;
    localparam int CNT_W = 16;
    localparam int DT_W  = 8;
`ifdef GATE_PATTERN_SHOOT_THROUGH_EN
    localparam logic FAULT_EXP = 1'b1;
`else
    localparam logic FAULT_EXP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             trigger;
    logic [3:0]       sp, ss;
    logic [CNT_W-1:0] period_cnt, v1_pos_cnt, v2_pos_cnt;
    logic [CNT_W:0]   phase_cnt;
    logic             phase_ok, meas_valid, timeout, fault;
    logic [DT_W-1:0]  dt_cnt;

    gate_pattern_decoder #(.CNT_W(CNT_W), .DT_W(DT_W)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .Sp(sp), .Ss(ss),
        .period_cnt(period_cnt), .v1_pos_cnt(v1_pos_cnt), .v2_pos_cnt(v2_pos_cnt),
        .phase_cnt(phase_cnt), .phase_ok(phase_ok), .dt_cnt(dt_cnt),
        .meas_valid(meas_valid), .timeout(timeout), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v1;
        int v2;
        int phase;
        int ok;
        int dt;
    } exp_t;

    typedef enum { PZ, PA, PB, PC, PD, PE } pat_e;

    exp_t sb_q[$];
    exp_t pending;
    logic armed;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic win(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Gate vectors for cycle c of a period (c=0 is the trigger cycle); returns {Sp, Ss}.
    function automatic logic [7:0] gates(input pat_e p, input int c);
        logic sp1, sp2, sp3, sp4, ss1, ss4;
        sp1 = 1'b0; sp2 = 1'b0; sp3 = 1'b0; sp4 = 1'b0; ss1 = 1'b0; ss4 = 1'b0;
        case (p)
            PA, PB: begin
                sp1 = win(c, 10, 489);  sp2 = win(c, 510, 989);
                sp3 = win(c, 520, 979); sp4 = win(c, 20, 479);
                if (p == PB) begin ss1 = win(c, 145, 400); ss4 = win(c, 145, 400); end
            end
            PC: begin
                sp1 = win(c, 145, 400); sp4 = win(c, 145, 400);
                ss1 = win(c, 20, 479);  ss4 = win(c, 20, 479);
            end
            PD: begin
                sp1 = win(c, 10, 489); sp2 = win(c, 497, 989); sp4 = win(c, 20, 479);
            end
            PE: begin
                sp1 = win(c, 290, 589); sp2 = win(c, 890, 989); sp4 = win(c, 290, 589);
            end
            default: ;
        endcase
        return {sp1, sp2, sp3, sp4, ss1, 1'b0, 1'b0, ss4};
    endfunction

    // One 1000-cycle period starting with a trigger; the trigger closes the previous period.
    task automatic run_period(input pat_e p, input exp_t e);
        if (armed) sb_q.push_back(pending);
        pending = e;
        armed   = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            trigger  = (c < 5);
            {sp, ss} = gates(p, c);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && meas_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_meas_valid", 32'(meas_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("period_cnt", 32'(period_cnt), 32'd1000);
                check("v1_pos_cnt", 32'(v1_pos_cnt), 32'(e.v1));
                check("v2_pos_cnt", 32'(v2_pos_cnt), 32'(e.v2));
                check("phase_cnt", {{(31-CNT_W){phase_cnt[CNT_W]}}, phase_cnt}, 32'(e.phase));
                check("phase_ok", 32'(phase_ok), 32'(e.ok));
                check("dt_cnt", 32'(dt_cnt), 32'(e.dt));
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; trigger = 1'b0; sp = 4'h0; ss = 4'h0; armed = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_period_cnt", 32'(period_cnt), 32'd0);
        check("rst_v1_pos_cnt", 32'(v1_pos_cnt), 32'd0);
        check("rst_v2_pos_cnt", 32'(v2_pos_cnt), 32'd0);
        check("rst_phase_cnt", 32'(phase_cnt), 32'd0);
        check("rst_phase_ok", 32'(phase_ok), 32'd0);
        check("rst_dt_cnt", 32'(dt_cnt), 32'd0);
        check("rst_meas_valid", 32'(meas_valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        run_period(PZ, '{v1: 0,   v2: 0,   phase: 0,    ok: 0, dt: 255});
        run_period(PA, '{v1: 460, v2: 0,   phase: 0,    ok: 0, dt: 20});
        run_period(PB, '{v1: 460, v2: 256, phase: 125,  ok: 1, dt: 20});
        // Sp1 rises at 145 after PB's Sp2 fell at 990: dead run 10+145 = 155.
        run_period(PC, '{v1: 256, v2: 460, phase: -125, ok: 1, dt: 155});
        run_period(PD, '{v1: 460, v2: 0,   phase: 0,    ok: 0, dt: 7});
        run_period(PE, '{v1: 300, v2: 0,   phase: 0,    ok: 0, dt: 255});

        // Final trigger, then silence until the period counter saturates.
        sb_q.push_back(pending);
        armed = 1'b0;
        @(posedge clk); #1;
        trigger = 1'b1; sp = 4'h0; ss = 4'h0;
        @(posedge clk); #1;
        trigger = 1'b0;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        check("timeout_before_sat", 32'(timeout), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("timeout_at_sat", 32'(timeout), 32'd1);
        check("hold_period_cnt", 32'(period_cnt), 32'd1000);
        check("hold_v1_pos_cnt", 32'(v1_pos_cnt), 32'd300);
        check("hold_dt_cnt", 32'(dt_cnt), 32'd255);
        check("hold_phase_ok", 32'(phase_ok), 32'd0);

        // Re-arm from IDLE: first trigger opens a period, second reports it.
        run_period(PZ, '{v1: 0, v2: 0, phase: 0, ok: 0, dt: 255});
        run_period(PZ, '{v1: 0, v2: 0, phase: 0, ok: 0, dt: 255});
        check("timeout_sticky", 32'(timeout), 32'd1);
        check("captures_outstanding", 32'(sb_q.size()), 32'd0);

        check("fault_before_pulse", 32'(fault), 32'd0);
        @(posedge clk); #1;
        sp = 4'b1100;
        @(posedge clk); #1;
        sp = 4'b0000;
        @(negedge clk);
        check("fault_after_pulse", 32'(fault), 32'(FAULT_EXP));
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("fault_sticky", 32'(fault), 32'(FAULT_EXP));

        rst = 1'b1;
        @(negedge clk);
        check("rst2_fault", 32'(fault), 32'd0);
        check("rst2_timeout", 32'(timeout), 32'd0);
        check("rst2_period_cnt", 32'(period_cnt), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gate_pattern_decoder.md
Name: gate_pattern_decoder

Overview:
- Receive-side counterpart of the DAB modulator: observes the primary/secondary gate vectors Sp/Ss and the period trigger, and recovers the applied modulation in clock cycles.
- Reports period, V1/V2 positive pulse widths, signed V1→V2 phase offset and minimum primary-leg deadtime once per switching period.
- Flags shoot-through and a missing trigger.
- Sits beside the modulator, same clk domain, feeding telemetry and closed-loop checks.

Parameters:
- CNT_W, 16, width of all unsigned cycle counters and results.
- DT_W, 8, width of the deadtime measurement (saturates at all-ones).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- trigger  in  1  period-start strobe from modulator (level; rising edge used)
- Sp  in  4  primary gates {Sp1,Sp2,Sp3,Sp4}, bit3=Sp1
- Ss  in  4  secondary gates {Ss1,Ss2,Ss3,Ss4}, bit3=Ss1
- period_cnt  out  CNT_W  cycles between last two trigger rising edges
- v1_pos_cnt  out  CNT_W  cycles with V1=+1 in last period
- v2_pos_cnt  out  CNT_W  cycles with V2=+1 in last period
- phase_cnt  out  CNT_W+1  signed, V2 rise time minus V1 rise time
- phase_ok  out  1  both rises seen in last period
- dt_cnt  out  DT_W  minimum primary leg-A dead interval in last period
- meas_valid  out  1  one-cycle strobe, results updated
- timeout  out  1  sticky, period counter saturated
- fault  out  1  sticky shoot-through flag

Behaviour:
- Level decode:
  - V1=+1 when Sp1&Sp4; V1=-1 when Sp2&Sp3; else 0.
  - V2 decoded the same way from Ss.
- Registers: trigger, V1pos and V2pos are each delayed one stage for edge detection. trig_rise = trigger & ~trig_d.
- Reset: all outputs 0; FSM in IDLE; all counters 0.
- IDLE: wait for trig_rise, then go to MEAS. All counters restart so the trig_rise cycle counts as cycle 0.
- MEAS:
  - Per cycle: tcnt increments; pos counters increment while V1pos / V2pos are high.
  - On a V1pos rising edge, the first one in the period stores t_v1=tcnt. V2 is handled the same way into t_v2.
  - Dead interval: cycles with Sp1=0 and Sp2=0 counted since last leg-A transition. On a leg-A gate rise, dt_min=min(dt_min,run), with the run saturating at 2^DT_W-1.
  - dt_min starts each period at all-ones. If no dead interval completes in the period, all-ones is reported.
- On trig_rise in MEAS, capture:
  - period_cnt=tcnt+1; pos counts include the current cycle sample.
  - phase_cnt=t_v2-t_v1, sign-extended to CNT_W+1. Negative means V2 leads.
  - phase_ok=both seen, else phase_cnt=0.
  - dt_cnt=dt_min.
- Capture timing: meas_valid is high the following cycle for exactly 1 cycle. All counters restart in the same cycle (seamless back-to-back periods).
- Latency: results are visible 1 clk after the trig_rise cycle.
- tcnt reaching 2^CNT_W-1 without trig_rise: set timeout, no meas_valid, return to IDLE. Outputs hold their last values.
- timeout and fault are sticky; cleared only by rst.
- Pos counters cannot exceed tcnt, so they need no saturation check.
- Simultaneous trig_rise and a V1/V2 rise: the edge belongs to the new period (t=0).
- rst asserted mid-period discards partial counts immediately (async). The first period after reset is never reported.

Optional Feature:
- Macro: GATE_PATTERN_SHOOT_THROUGH_EN.
- Defined: fault sets the cycle after any of (Sp1&Sp2), (Sp3&Sp4), (Ss1&Ss2), (Ss3&Ss4) is sampled high. It stays set until rst.
- Undefined: fault tied 0, detection logic absent.

Test Plan:
- Rst, then trigger pulses every 1000 clk, Sp/Ss static 0 → first meas_valid after the second trigger; period_cnt=1000, v1_pos_cnt=0, phase_ok=0, dt_cnt=255.
- Symmetric primary pattern: period 1000, V1=+1 for cycles 20..479, V1=-1 for 520..979, leg-A dead gaps of 20 → v1_pos_cnt=460, dt_cnt=20.
- V1 rises at cycle 20, V2 at 145 → phase_cnt=+125, phase_ok=1. Swap the rises (V2 at 20, V1 at 145) → phase_cnt=-125.
- Dead gaps of 20 and 7 cycles in one period → dt_cnt=7. Next period all gaps 300 → dt_cnt=255.
- Stop trigger after one period → at tcnt=65535 timeout=1, no meas_valid, outputs hold. A new trigger re-arms: IDLE, then a valid capture one period later.
- Macro defined: Sp1=Sp2=1 for 1 cycle → fault=1 next cycle, persists through triggers until rst. Macro undefined: fault stays 0.
